// File: rtl/ysyx_23060180_lsu.sv
// Load/store unit: one outstanding core request, aligned memory port with byte lanes,
// sign/zero extension of load data and a bounded wait on the memory handshake.
module ysyx_23060180_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rstn_in,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int STRB_W  = XLEN / 8;
  localparam int LANE_W  = $clog2(STRB_W);
  localparam int CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  function automatic logic [7:0] byte_mask(input logic [1:0] size);
    case (size)
      2'd0:    byte_mask = 8'h01;
      2'd1:    byte_mask = 8'h03;
      2'd2:    byte_mask = 8'h0F;
      default: byte_mask = 8'hFF;
    endcase
  endfunction

  // Move the addressed bytes to bit 0, then push them to the top and shift back down
  // so the fill is either the sign bit or zero.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [LANE_W-1:0] lane,
                                                  input logic [1:0] size,
                                                  input logic uns);
    logic [XLEN-1:0] aligned;
    logic [XLEN-1:0] tmp;
    logic [6:0]      sh;
    aligned = word >> {lane, 3'b000};
    case (size)
      2'd0:    sh = 7'(XLEN - 8);
      2'd1:    sh = 7'(XLEN - 16);
      2'd2:    sh = 7'(XLEN - 32);
      default: sh = 7'd0;
    endcase
    tmp = aligned << sh;
    if (uns) begin
      load_extend = tmp >> sh;
    end else begin
      load_extend = $signed(tmp) >>> sh;
    end
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_n_s;
  logic              we_r;
  logic              uns_r;
  logic [1:0]        size_r;
  logic [LANE_W-1:0] lane_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              accept_s;
  logic              misalign_s;
  logic              bad_s;
  logic              timeout_s;
  logic              we_sel_s;
  logic              err_n_s;
  logic [XLEN-1:0]   rdata_n_s;
  logic [7:0]        strb_s;

  assign accept_s  = req_valid && req_ready;
  assign bad_s     = misalign_s || ((req_size == 2'd3) && (XLEN == 32));
  assign timeout_s = (TIMEOUT != 0) && (cnt_r == CNT_W'(TO_LAST));
  assign we_sel_s  = accept_s ? req_we : we_r;
  assign strb_s    = byte_mask(req_size) << req_addr[LANE_W-1:0];

  // Alignment check of the incoming request against its access size.
  always_comb begin
    case (req_size)
      2'd0:    misalign_s = 1'b0;
      2'd1:    misalign_s = req_addr[0];
      2'd2:    misalign_s = |req_addr[1:0];
      default: misalign_s = |req_addr[2:0];
    endcase
  end

  // Next state plus the response captured on entry to RESP; timeout beats gnt/rvalid.
  always_comb begin
    state_n_s = state_r;
    err_n_s   = 1'b0;
    rdata_n_s = '0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            state_n_s = S_RESP;
            err_n_s   = 1'b1;
          end else begin
            state_n_s = S_REQ;
          end
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (timeout_s) begin
          state_n_s = S_RESP;
          err_n_s   = 1'b1;
        end else if (mem_gnt) begin
          state_n_s = we_r ? S_RESP : S_WAIT;
        end else begin
          state_n_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (timeout_s) begin
          state_n_s = S_RESP;
          err_n_s   = 1'b1;
        end else if (mem_rvalid) begin
          state_n_s = S_RESP;
          rdata_n_s = load_extend(mem_rdata, lane_r, size_r, uns_r);
        end else begin
          state_n_s = S_WAIT;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_RESP;
        end
      end
      default: state_n_s = S_IDLE;
    endcase
  end

  // State, request capture, timeout counter and all registered outputs.
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      state_r    <= S_IDLE;
      we_r       <= 1'b0;
      uns_r      <= 1'b0;
      size_r     <= 2'd0;
      lane_r     <= '0;
      cnt_r      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      state_r    <= state_n_s;
      req_ready  <= (state_n_s == S_IDLE);
      resp_valid <= (state_n_s == S_RESP);
      mem_req    <= (state_n_s == S_REQ);
      mem_we     <= (state_n_s == S_REQ) && we_sel_s;
      if (accept_s) begin
        we_r      <= req_we;
        uns_r     <= req_unsigned;
        size_r    <= req_size;
        lane_r    <= req_addr[LANE_W-1:0];
        mem_addr  <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        mem_wdata <= req_we ? (req_wdata << {req_addr[LANE_W-1:0], 3'b000}) : '0;
      end
      // Strobes exist only while a store is actually being presented.
      if ((state_n_s == S_REQ) && we_sel_s) begin
        if (accept_s) begin
          mem_wstrb <= strb_s[STRB_W-1:0];
        end
      end else begin
        mem_wstrb <= '0;
      end
      if (accept_s) begin
        cnt_r <= '0;
      end else if ((state_r == S_REQ) || (state_r == S_WAIT)) begin
        cnt_r <= cnt_r + 1'b1;
      end
      if ((state_r != S_RESP) && (state_n_s == S_RESP)) begin
        resp_err   <= err_n_s;
        resp_rdata <= rdata_n_s;
      end else if ((state_r == S_RESP) && (state_n_s == S_IDLE)) begin
        resp_err   <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060180_lsu.sv
// Scoreboard bench for the LSU: a 32-bit instance (short timeout) and a 64-bit instance
// share one stimulus set, selected by sel; a small memory responder drives gnt/rvalid.
module tb_ysyx_23060180_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        sel;
  logic        req_valid, req_we, req_unsigned, resp_ready, mem_gnt, mem_rvalid;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wstrb;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req, b_mem_we;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_wstrb;

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_23060180_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rstn_in(rstn),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata[31:0]), .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_req(a_mem_req),
    .mem_gnt(mem_gnt & ~sel), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb), .mem_rvalid(mem_rvalid & ~sel),
    .mem_rdata(mem_rdata[31:0])
  );

  ysyx_23060180_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(255)) u_b (
    .clk(clk), .rstn_in(rstn),
    .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_req(b_mem_req),
    .mem_gnt(mem_gnt & sel), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb), .mem_rvalid(mem_rvalid & sel),
    .mem_rdata(mem_rdata)
  );

  assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
  assign o_resp_rdata = sel ? b_resp_rdata : {32'd0, a_resp_rdata};
  assign o_mem_req    = sel ? b_mem_req    : a_mem_req;
  assign o_mem_we     = sel ? b_mem_we     : a_mem_we;
  assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
  assign o_mem_wdata  = sel ? b_mem_wdata  : {32'd0, a_mem_wdata};
  assign o_mem_wstrb  = sel ? b_mem_wstrb  : {4'd0, a_mem_wstrb};

  // One transaction: push the expectation, drive it, answer on the memory side
  // (gnt in REQ cycle gnt_at, 0 = never; rvalid always up), pop on resp_valid.
  task automatic run_xact(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int gnt_at, input int hold,
                          input logic [63:0] exp_rdata, input logic exp_err, input int exp_lat,
                          input int exp_nreq, input logic [31:0] exp_maddr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
    exp_t        e;
    int          nreq, lat;
    bit          got, unstable, leak;
    logic [31:0] f_addr;
    logic [63:0] f_wdata, r_data;
    logic [7:0]  f_wstrb;
    logic        f_we, r_err;
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    nreq = 0; lat = 0; got = 0; unstable = 0; leak = 0;
    f_addr = '0; f_wdata = '0; f_wstrb = '0; f_we = 1'b0; r_data = '0; r_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (o_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_ready: got %b want 1", name, o_req_ready);
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; mem_rdata = rdata;
    mem_rvalid = 1'b1; mem_gnt = 1'b0; resp_ready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (k == 1) begin
        n_checks++;
        if (o_req_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s busy_ready: got %b want 0", name, o_req_ready);
        end
      end
      if (o_mem_req === 1'b1) begin
        nreq++;
        if (nreq == 1) begin
          f_addr = o_mem_addr; f_wdata = o_mem_wdata; f_wstrb = o_mem_wstrb; f_we = o_mem_we;
        end else if (o_mem_addr !== f_addr || o_mem_wdata !== f_wdata ||
                     o_mem_wstrb !== f_wstrb || o_mem_we !== f_we) begin
          unstable = 1'b1;
        end
        mem_gnt = (nreq == gnt_at);
      end else begin
        mem_gnt = 1'b0;
        if (o_mem_wstrb !== 8'd0) leak = 1'b1;
      end
      if (o_resp_valid === 1'b1) begin
        got = 1'b1; lat = k; r_data = o_resp_rdata; r_err = o_resp_err; mem_gnt = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (r_data !== e.rdata) begin
          n_fail++; $display("FAIL %s rdata: got %h want %h", name, r_data, e.rdata);
        end
        n_checks++;
        if (r_err !== e.err) begin
          n_fail++; $display("FAIL %s err: got %b want %b", name, r_err, e.err);
        end
        n_checks++;
        if (lat != e.lat) begin
          n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
        end
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (o_resp_valid !== 1'b1 || o_resp_rdata !== r_data || o_resp_err !== r_err)
            unstable = 1'b1;
        end
        resp_ready = 1'b1;
        n_checks++;
        if (o_req_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s exit_ready: got %b want 0", name, o_req_ready);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if (o_req_ready !== 1'b1 || o_resp_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s back_idle: ready %b valid %b want 1 0", name, o_req_ready, o_resp_valid);
        end
        break;
      end
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL %s no_response: got none want one within 40 cycles", name);
      e = sb.pop_front();
    end
    n_checks++;
    if (nreq != exp_nreq) begin
      n_fail++; $display("FAIL %s mem_req_cycles: got %0d want %0d", name, nreq, exp_nreq);
    end
    n_checks++;
    if (unstable || leak) begin
      n_fail++; $display("FAIL %s stability: unstable %b strobe_leak %b want 0 0", name, unstable, leak);
    end
    if (exp_nreq > 0) begin
      n_checks++;
      if (f_addr !== exp_maddr || f_we !== we || f_wstrb !== exp_wstrb) begin
        n_fail++;
        $display("FAIL %s mem_port: addr %h we %b strb %h want %h %b %h",
                 name, f_addr, f_we, f_wstrb, exp_maddr, we, exp_wstrb);
      end
      if (we) begin
        n_checks++;
        if (f_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL %s mem_wdata: got %h want %h", name, f_wdata, exp_wdata);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #2 rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_checks++;
      if ({o_req_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we} !== 5'b10000) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d]: got %b want 10000", s,
                 {o_req_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we});
      end
      n_checks++;
      if (o_resp_rdata !== 64'd0 || o_mem_addr !== 32'd0 || o_mem_wdata !== 64'd0 || o_mem_wstrb !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_data[%0d]: rdata %h addr %h wdata %h strb %h want 0", s,
                 o_resp_rdata, o_mem_addr, o_mem_wdata, o_mem_wstrb);
      end
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_ext();
    sel = 1'b0;
    run_xact("lb", 1'b0, 2'd0, 1'b0, 32'h8000_0003, 64'd0, 64'h80FF_FFFF, 1, 0,
             64'h0000_0000_FFFF_FF80, 1'b0, 3, 1, 32'h8000_0000, 64'd0, 8'h00);
    run_xact("lbu", 1'b0, 2'd0, 1'b1, 32'h8000_0003, 64'd0, 64'h80FF_FFFF, 1, 0,
             64'h0000_0000_0000_0080, 1'b0, 3, 1, 32'h8000_0000, 64'd0, 8'h00);
    run_xact("lh_gnt2", 1'b0, 2'd1, 1'b0, 32'h8000_0006, 64'd0, 64'h8001_2345, 2, 1,
             64'h0000_0000_FFFF_8001, 1'b0, 4, 2, 32'h8000_0004, 64'd0, 8'h00);
  endtask

  task automatic test_store_lanes();
    sel = 1'b0;
    run_xact("sh", 1'b1, 2'd1, 1'b0, 32'h8000_0002, 64'h1234_ABCD, 64'd0, 1, 0,
             64'd0, 1'b0, 2, 1, 32'h8000_0000, 64'h0000_0000_ABCD_0000, 8'h0C);
    run_xact("sb", 1'b1, 2'd0, 1'b0, 32'h8000_0001, 64'hFFFF_FF5A, 64'd0, 1, 0,
             64'd0, 1'b0, 2, 1, 32'h8000_0000, 64'h0000_0000_FFFF_5A00, 8'h02);
    run_xact("sw_gnt2", 1'b1, 2'd2, 1'b0, 32'h8000_0008, 64'hCAFE_F00D, 64'd0, 2, 2,
             64'd0, 1'b0, 3, 2, 32'h8000_0008, 64'h0000_0000_CAFE_F00D, 8'h0F);
  endtask

  task automatic test_errors();
    sel = 1'b0;
    run_xact("lw_misaligned", 1'b0, 2'd2, 1'b0, 32'h8000_0002, 64'd0, 64'hFFFF_FFFF, 1, 0,
             64'd0, 1'b1, 1, 0, 32'd0, 64'd0, 8'h00);
    run_xact("sh_misaligned", 1'b1, 2'd1, 1'b0, 32'h8000_0001, 64'h55AA, 64'd0, 1, 0,
             64'd0, 1'b1, 1, 0, 32'd0, 64'd0, 8'h00);
    run_xact("ld_on_rv32", 1'b0, 2'd3, 1'b0, 32'h8000_0000, 64'd0, 64'h1234_5678, 1, 0,
             64'd0, 1'b1, 1, 0, 32'd0, 64'd0, 8'h00);
  endtask

  task automatic test_timeout();
    sel = 1'b0;
    run_xact("timeout_no_gnt", 1'b0, 2'd2, 1'b0, 32'h8000_0010, 64'd0, 64'h7777_7777, 0, 1,
             64'd0, 1'b1, 5, 4, 32'h8000_0010, 64'd0, 8'h00);
    run_xact("timeout_in_wait", 1'b0, 2'd2, 1'b0, 32'h8000_0014, 64'd0, 64'h6666_6666, 3, 0,
             64'd0, 1'b1, 5, 3, 32'h8000_0014, 64'd0, 8'h00);
    repeat (2) begin
      mem_rvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL late_rvalid: valid %b ready %b want 0 1", o_resp_valid, o_req_ready);
      end
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    bit bad;
    sel = 1'b0;
    run_xact("lw_hold5", 1'b0, 2'd2, 1'b0, 32'h8000_0004, 64'd0, 64'hDEAD_BEEF, 1, 5,
             64'h0000_0000_DEAD_BEEF, 1'b0, 3, 1, 32'h8000_0004, 64'd0, 8'h00);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h8000_0020; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (o_mem_req !== 1'b1) begin
      n_fail++; $display("FAIL midreset_req: mem_req %b want 1", o_mem_req);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    n_checks++;
    if (o_mem_req !== 1'b0 || o_resp_valid !== 1'b0 || o_req_ready !== 1'b0 || o_mem_addr !== 32'h8000_0020) begin
      n_fail++;
      $display("FAIL midreset_wait: req %b valid %b ready %b addr %h want 0 0 0 80000020",
               o_mem_req, o_resp_valid, o_req_ready, o_mem_addr);
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({o_req_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we} !== 5'b10000 ||
        o_resp_rdata !== 64'd0 || o_mem_addr !== 32'd0 || o_mem_wdata !== 64'd0 || o_mem_wstrb !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: ctrl %b addr %h rdata %h want 10000 0 0",
               {o_req_ready, o_resp_valid, o_resp_err, o_mem_req, o_mem_we}, o_mem_addr, o_resp_rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1122_3344;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0 || o_req_ready !== 1'b1) bad = 1'b1;
    end
    mem_rvalid = 1'b0;
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL post_reset_rvalid: stray response seen, want none");
    end
  endtask

  task automatic test_xlen64();
    sel = 1'b1;
    run_xact("ld64", 1'b0, 2'd3, 1'b0, 32'h0000_0008, 64'd0, 64'h8000_0000_0000_0001, 1, 0,
             64'h8000_0000_0000_0001, 1'b0, 3, 1, 32'h0000_0008, 64'd0, 8'h00);
    run_xact("lw64", 1'b0, 2'd2, 1'b0, 32'h0000_000C, 64'd0, 64'h8000_0000_0000_0001, 1, 0,
             64'hFFFF_FFFF_8000_0000, 1'b0, 3, 1, 32'h0000_0008, 64'd0, 8'h00);
    run_xact("lwu64", 1'b0, 2'd2, 1'b1, 32'h0000_000C, 64'd0, 64'h8000_0000_0000_0001, 1, 0,
             64'h0000_0000_8000_0000, 1'b0, 3, 1, 32'h0000_0008, 64'd0, 8'h00);
    run_xact("sd64", 1'b1, 2'd3, 1'b0, 32'h0000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 0,
             64'd0, 1'b0, 2, 1, 32'h0000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF);
    run_xact("sh64", 1'b1, 2'd1, 1'b0, 32'h0000_0016, 64'h0000_0000_0000_BEEF, 64'd0, 1, 0,
             64'd0, 1'b0, 2, 1, 32'h0000_0010, 64'hBEEF_0000_0000_0000, 8'hC0);
    run_xact("ld64_misaligned", 1'b0, 2'd3, 1'b0, 32'h0000_0004, 64'd0, 64'h1, 1, 0,
             64'd0, 1'b1, 1, 0, 32'd0, 64'd0, 8'h00);
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 64'd0; resp_ready = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 64'd0;
    test_reset();
    test_load_ext();
    test_store_lanes();
    test_errors();
    test_timeout();
    test_backpressure_reset();
    test_xlen64();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_23060180_lsu.md
YSYX_23060180_LSU -- requirements
Module: ysyx_23060180_lsu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent waiting on memory; 0 disables the timeout.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rstn_in  in  1  reset; asynchronous, active-low.
REQ-006 req_valid  in  1  core request valid.
REQ-007 req_ready  out  1  LSU can accept a request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  0 byte, 1 half, 2 word, 3 double.
REQ-010 req_unsigned  in  1  zero-extend load data (lbu/lhu/lwu).
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  XLEN  store data, right-aligned.
REQ-013 resp_valid  out  1  response valid.
REQ-014 resp_ready  in  1  core accepts the response.
REQ-015 resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-016 resp_err  out  1  misaligned, illegal size, or timeout.
REQ-017 mem_req  out  1  memory request.
REQ-018 mem_gnt  in  1  memory accepted mem_req this cycle.
REQ-019 mem_we  out  1  memory write.
REQ-020 mem_addr  out  ADDR_W  req_addr with its low log2(XLEN/8) bits cleared.
REQ-021 mem_wdata  out  XLEN  store data shifted to its byte lane.
REQ-022 mem_wstrb  out  XLEN/8  byte write enables.
REQ-023 mem_rvalid  in  1  read data valid.
REQ-024 mem_rdata  in  XLEN  aligned read word.

Function
REQ-025 FSM states: IDLE, REQ, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-026 Request acceptance (req_valid && req_ready) SHALL register we, size, unsigned, addr, and wdata; registered values SHALL hold until return to IDLE.
REQ-027 At acceptance, the LSU SHALL flag an error and go IDLE->RESP if the request is:
- misaligned: addr not a multiple of 2^size; or
- illegal size: size==3 with XLEN==32.
No mem_req SHALL be issued in that case.
REQ-028 Otherwise IDLE->REQ; mem_req SHALL stay 1 in REQ until mem_gnt, with mem_addr, mem_we, mem_wdata, and mem_wstrb stable.
REQ-029 REQ with mem_gnt: stores SHALL go to RESP; loads SHALL go to WAIT.
REQ-030 WAIT with mem_rvalid: loads SHALL capture the extended data and go to RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-031 Lane math: lane = addr[log2(XLEN/8)-1:0].
- mem_wdata = wdata << 8*lane.
- mem_wstrb = ((1<<2^size)-1) << lane.
- Loads: data = mem_rdata >> 8*lane, then truncated to 2^size bytes, then sign-extended or zero-extended to XLEN.
REQ-032 mem_wstrb SHALL be 0 whenever mem_req is 0 or mem_we is 0.
REQ-033 Timeout counter:
- cleared on entry to REQ;
- incremented each cycle in REQ and WAIT;
- when it reaches TIMEOUT (nonzero), the FSM SHALL go to RESP with resp_err=1, dropping mem_req the same cycle;
- a gnt or rvalid arriving in that cycle SHALL be ignored.
REQ-034 RESP: resp_valid=1, and resp_rdata/resp_err SHALL be held stable until resp_ready; RESP with resp_ready SHALL go to IDLE.
REQ-035 No new request SHALL be accepted in the RESP-exit cycle; minimum load latency, acceptance to resp_valid, SHALL be 3 cycles (gnt in first REQ cycle, rvalid in first WAIT cycle).
REQ-036 A store with zero-wait gnt SHALL show resp_valid 2 cycles after acceptance.

Reset
REQ-037 rstn_in low SHALL immediately force:
- state IDLE and counter 0;
- req_ready=1;
- resp_valid=0, resp_err=0, resp_rdata=0;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
REQ-038 Reset mid-transaction SHALL abandon it with no response; memory responses arriving after reset SHALL be ignored.

Verification
REQ-039 XLEN=32, lb addr 0x80000003, mem_rdata 0x80FFFFFF, gnt and rvalid immediate -> mem_addr 0x80000000; resp_rdata 0xFFFFFF80 at cycle 3; lbu gives 0x00000080.
REQ-040 XLEN=32, sh addr 0x80000002, wdata 0x1234ABCD -> mem_wstrb 0b1100, mem_wdata 0xABCD0000, resp_err=0.
REQ-041 lw addr 0x80000002 -> mem_req never asserted; resp_valid 1 cycle later with resp_err=1, resp_rdata=0.
REQ-042 TIMEOUT=4, load, mem_gnt held 0 -> mem_req for 4 cycles, then resp_err=1; a later mem_rvalid is ignored.
REQ-043 XLEN=64, ld addr 0x8, mem_rdata 0x8000000000000001 -> resp_rdata unchanged; lw addr 0xC with the same mem_rdata -> 0xFFFFFFFF80000000.
REQ-044 resp_ready held 0 for 5 cycles, then reset asserted mid-WAIT on a next request -> response stable over those 5 cycles; reset clears all outputs immediately.
